clk_div_monitor: RTL and testbench

//  Consumes the divided clock from clk_div_3 (or any clk_div_* stage) as a plain data signal,

---
 rtl/desynk_pkg.sv | 12 +
 rtl/clk_edge_detect.sv | 24 ++
 rtl/clk_div_monitor.sv | 149 ++++++++++++++
 tb/tb_clk_div_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/desynk_pkg.sv
// rtl/desynk_pkg.sv - shared types and defaults for divided-clock monitoring
package desynk_pkg;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_LOCK_COUNT = 4;

    typedef enum logic [0:0] {
        MON_WAIT_EDGE = 1'b0,
        MON_MEASURE   = 1'b1
    } mon_state_e;

endpackage

// File: rtl/clk_edge_detect.sv
// rtl/clk_edge_detect.sv - one-cycle rise/fall strobes for a signal sampled as data
module clk_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev;

    // Previous sample; cleared on reset so a high level right after reset reads as a rise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures period/high-time of a divided clock and reports lock/errors
module clk_div_monitor
    import desynk_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             div_clk_i,
    input  logic [CNT_W-1:0] exp_period_i,
    input  logic [CNT_W-1:0] exp_high_i,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             stall_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam int               LC_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [LC_W-1:0]  LC_TARGET = LC_W'(LOCK_COUNT);

    mon_state_e       r_state;
    mon_state_e       w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_meas_valid;
    logic             r_locked;
    logic             r_err;
    logic             r_stall;
    logic [LC_W-1:0]  r_lock_cnt;

    logic             w_rise;
    logic             w_fall_unused;
    logic             w_measuring;
    logic             w_meas;
    logic             w_stall;
    logic             w_match;
    logic [LC_W-1:0]  w_lock_inc;

    clk_edge_detect u_edge (
        .i_clk   (clk_i),
        .i_rst_n (rst),
        .i_sig   (div_clk_i),
        .o_rise  (w_rise),
        .o_fall  (w_fall_unused)
    );

    assign w_measuring = (r_state == MON_MEASURE);
    assign w_meas      = w_measuring && w_rise;
    assign w_stall     = w_measuring && !w_rise && (r_cnt == CNT_MAX);
    assign w_match     = (r_cnt == exp_period_i) && (r_hcnt == exp_high_i);
    assign w_lock_inc  = (r_lock_cnt >= LC_TARGET) ? LC_TARGET : r_lock_cnt + LC_W'(1);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            r_state <= MON_WAIT_EDGE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: start measuring on the first rise, fall back to waiting on a stall.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MON_WAIT_EDGE: if (w_rise)  w_next_state = MON_MEASURE;
            MON_MEASURE:   if (w_stall) w_next_state = MON_WAIT_EDGE;
            default:       w_next_state = MON_WAIT_EDGE;
        endcase
    end

    // Period/high counters, measurement capture, lock tracking and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_stall      <= 1'b0;
            r_lock_cnt   <= '0;
        end else begin
            r_meas_valid <= 1'b0;

            if (!w_measuring) begin
                // The cycle of the first rise is the first cycle of the first measured period.
                if (w_rise) begin
                    r_cnt  <= CNT_W'(1);
                    r_hcnt <= CNT_W'(1);
                end
            end else if (w_rise) begin
                r_cnt        <= CNT_W'(1);
                r_hcnt       <= CNT_W'(1);
                r_period     <= r_cnt;
                r_high       <= r_hcnt;
                r_meas_valid <= 1'b1;
                if (w_match) begin
                    r_lock_cnt <= w_lock_inc;
                    r_locked   <= (w_lock_inc >= LC_TARGET);
                end else begin
                    r_lock_cnt <= '0;
                    r_locked   <= 1'b0;
                end
            end else if (w_stall) begin
                r_cnt      <= '0;
                r_hcnt     <= '0;
                r_lock_cnt <= '0;
                r_locked   <= 1'b0;
            end else begin
                // r_cnt is below CNT_MAX here (otherwise this is a stall), so no wrap.
                r_cnt <= r_cnt + CNT_W'(1);
                if (div_clk_i && (r_hcnt != CNT_MAX)) begin
                    r_hcnt <= r_hcnt + CNT_W'(1);
                end
            end

            // A new error in the same cycle as a clear keeps the flag set.
            if (w_stall || (w_meas && !w_match)) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end

            if (w_stall) begin
                r_stall <= 1'b1;
            end else if (err_clr_i) begin
                r_stall <= 1'b0;
            end
        end
    end

    assign period_o     = r_period;
    assign high_o       = r_high;
    assign meas_valid_o = r_meas_valid;
    assign locked_o     = r_locked;
    assign err_o        = r_err;
    assign stall_o      = r_stall;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - scoreboard bench for clk_div_monitor
module tb_clk_div_monitor;

    localparam int CW    = 4;
    localparam int LOCKN = 4;
    localparam int CMAX  = 15;

    typedef struct {
        int p;
        int h;
        bit lk;
        bit er;
    } meas_t;

    logic          clk_i = 1'b0;
    logic          rst = 1'b0;
    logic          div_clk_i = 1'b0;
    logic [CW-1:0] exp_period_i = 4'd3;
    logic [CW-1:0] exp_high_i = 4'd1;
    logic          err_clr_i = 1'b0;
    logic [CW-1:0] period_o;
    logic [CW-1:0] high_o;
    logic          meas_valid_o;
    logic          locked_o;
    logic          err_o;
    logic          stall_o;

    int    n_checks = 0;
    int    n_errors = 0;
    int    n_meas = 0;
    meas_t sb[$];
    meas_t mon_e;

    bit m_last = 0, m_armed = 0, m_locked = 0, m_err = 0, m_stall = 0;
    int m_cur_p = 0, m_cur_h = 0, m_streak = 0;

    clk_div_monitor #(.CNT_W(CW), .LOCK_COUNT(LOCKN)) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .div_clk_i    (div_clk_i),
        .exp_period_i (exp_period_i),
        .exp_high_i   (exp_high_i),
        .err_clr_i    (err_clr_i),
        .period_o     (period_o),
        .high_o       (high_o),
        .meas_valid_o (meas_valid_o),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .stall_o      (stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Pop one expected measurement per meas_valid pulse.
    always @(negedge clk_i) begin
        if (meas_valid_o === 1'b1) begin
            n_meas++;
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL meas_unexpected t=%0t period=%0d high=%0d", $time, period_o, high_o);
            end else begin
                mon_e = sb.pop_front();
                if (period_o !== CW'(mon_e.p) || high_o !== CW'(mon_e.h) ||
                    locked_o !== mon_e.lk || err_o !== mon_e.er) begin
                    n_errors++;
                    $display("FAIL meas t=%0t got p=%0d h=%0d lk=%b er=%b expected p=%0d h=%0d lk=%b er=%b",
                             $time, period_o, high_o, locked_o, err_o, mon_e.p, mon_e.h, mon_e.lk, mon_e.er);
                end
            end
        end
    end

    // One clk_i cycle of stimulus; updates the period-level model and checks the sticky flags.
    task automatic drive(input logic v, input logic clr = 1'b0, input logic rn = 1'b1);
        bit    rise_now, mism, stall_now, match, do_push;
        meas_t e;
        div_clk_i = v;
        err_clr_i = clr;
        rst       = rn;
        rise_now  = v && !m_last;
        m_last    = v;
        mism      = 0;
        stall_now = 0;
        do_push   = 0;
        if (!rn) begin
            m_last = 0; m_armed = 0; m_locked = 0; m_err = 0; m_stall = 0;
            m_streak = 0; m_cur_p = 0; m_cur_h = 0;
        end else begin
            if (m_armed && rise_now) begin
                match = (m_cur_p == int'(exp_period_i)) && (m_cur_h == int'(exp_high_i));
                if (match) begin
                    if (m_streak < LOCKN) m_streak++;
                end else begin
                    m_streak = 0;
                end
                m_locked = (m_streak >= LOCKN);
                mism     = !match;
                e.p      = m_cur_p;
                e.h      = m_cur_h;
                do_push  = 1;
                m_cur_p  = 1;
                m_cur_h  = 1;
            end else if (m_armed) begin
                if (m_cur_p == CMAX) begin
                    stall_now = 1; m_armed = 0; m_streak = 0; m_locked = 0;
                end else begin
                    m_cur_p++;
                    m_cur_h += int'(v);
                end
            end else if (rise_now) begin
                m_armed = 1; m_cur_p = 1; m_cur_h = 1;
            end
            m_err   = (mism || stall_now) ? 1'b1 : (clr ? 1'b0 : m_err);
            m_stall = stall_now ? 1'b1 : (clr ? 1'b0 : m_stall);
            if (do_push) begin
                e.lk = m_locked;
                e.er = m_err;
                sb.push_back(e);
            end
        end
        @(posedge clk_i);
        #1;
        n_checks += 3;
        if (err_o !== m_err) begin
            n_errors++;
            $display("FAIL err_flag t=%0t got %b expected %b", $time, err_o, m_err);
        end
        if (stall_o !== m_stall) begin
            n_errors++;
            $display("FAIL stall_flag t=%0t got %b expected %b", $time, stall_o, m_stall);
        end
        if (locked_o !== m_locked) begin
            n_errors++;
            $display("FAIL locked_flag t=%0t got %b expected %b", $time, locked_o, m_locked);
        end
        err_clr_i = 1'b0;
        rst       = 1'b1;
    endtask

    // One divided period: h cycles high then p-h low; optional clear on cycle clr_idx.
    task automatic period(input int p, input int h, input int clr_idx = -1);
        for (int i = 0; i < p; i++) begin
            drive(logic'(i < h), logic'(i == clr_idx));
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (period_o !== 4'd0 || high_o !== 4'd0 || meas_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs got p=%0d h=%0d v=%b expected 0 0 0", period_o, high_o, meas_valid_o);
        end
    endtask

    task automatic test_lock();
        int n0 = n_meas;
        repeat (6) period(3, 1);
        n_checks++;
        if (n_meas - n0 !== 5) begin
            n_errors++;
            $display("FAIL lock_meas_count got %0d expected 5", n_meas - n0);
        end
        n_checks++;
        if (locked_o !== 1'b1 || err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL lock_state got locked=%b err=%b expected 1 0", locked_o, err_o);
        end
    endtask

    task automatic test_mismatch();
        period(4, 1);
        repeat (5) period(3, 1);
        n_checks++;
        if (locked_o !== 1'b1 || err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL relock got locked=%b err=%b expected 1 1", locked_o, err_o);
        end
    endtask

    task automatic test_clear();
        period(4, 1);
        period(3, 1, 0);
        n_checks++;
        if (err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_vs_set got %b expected 1", err_o);
        end
        period(3, 1, 1);
        n_checks++;
        if (err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_alone got %b expected 0", err_o);
        end
    endtask

    task automatic test_stall();
        int n0;
        repeat (20) drive(1'b0);
        n_checks++;
        if (stall_o !== 1'b1 || err_o !== 1'b1 || locked_o !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_low got stall=%b err=%b locked=%b expected 1 1 0", stall_o, err_o, locked_o);
        end
        n0 = n_meas;
        period(3, 1);
        n_checks++;
        if (n_meas !== n0) begin
            n_errors++;
            $display("FAIL stall_first_rise got %0d pulses expected 0", n_meas - n0);
        end
        period(3, 1);
        n_checks++;
        if (n_meas !== n0 + 1) begin
            n_errors++;
            $display("FAIL stall_second_rise got %0d pulses expected 1", n_meas - n0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        drive(1'b0, 1'b1);
        repeat (5) period(3, 1);
        n_checks++;
        if (locked_o !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_lock got %b expected 1", locked_o);
        end
        drive(1'b1);
        drive(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (period_o !== 4'd0 || high_o !== 4'd0 || meas_valid_o !== 1'b0 || locked_o !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset got p=%0d h=%0d v=%b lk=%b expected 0 0 0 0",
                     period_o, high_o, meas_valid_o, locked_o);
        end
        n0 = n_meas;
        period(3, 1);
        period(3, 1);
        n_checks++;
        if (n_meas !== n0 + 1) begin
            n_errors++;
            $display("FAIL reset_restart got %0d pulses expected 1", n_meas - n0);
        end
    endtask

    task automatic test_high_stuck();
        int n0;
        period(3, 1);
        period(3, 1);
        n0 = n_meas;
        repeat (20) drive(1'b1);
        n_checks++;
        if (stall_o !== 1'b1 || high_o !== 4'd1 || n_meas !== n0 + 1) begin
            n_errors++;
            $display("FAIL high_stuck got stall=%b high=%0d pulses=%0d expected 1 1 1",
                     stall_o, high_o, n_meas - n0);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_mismatch();
        test_clear();
        test_stall();
        test_reset_mid();
        test_high_stuck();
        @(negedge clk_i);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
